// File: rtl/turf_header_generator_v3.sv
// TURF event-header builder: windowed metadata capture feeding a decoupled
// 64-bit AXI4-Stream header emitter, all in the trigger clock domain.
module turf_header_generator_v3 #(
  parameter int NUM_TIO     = 4,
  parameter int META_WINDOW = 16,
  parameter int HDR_QWORDS  = 16,
  parameter int SURF_WORDS  = 64
) (
  input  logic                   sysclk,
  input  logic                   sysresetn,
  input  logic                   runrst_i,
  input  logic                   runstop_i,
  input  logic [NUM_TIO-1:0]     tio_mask_i,
  input  logic [11:0]            runcfg_i,
  input  logic                   trig_i,
  input  logic [NUM_TIO*64-1:0]  metadata_i,
  input  logic [31:0]            cur_sec_i,
  input  logic [31:0]            cur_time_i,
  input  logic [31:0]            last_pps_i,
  input  logic [31:0]            llast_pps_i,
  output logic                   event_o,
  output logic [15:0]            drop_count_o,
  output logic [63:0]            m_thdr_tdata,
  output logic                   m_thdr_tvalid,
  input  logic                   m_thdr_tready,
  output logic                   m_thdr_tlast
);

  localparam int unsigned NT = NUM_TIO;
  localparam int unsigned MB = NUM_TIO * 64;
  localparam int unsigned NB = NUM_TIO * 8;
  localparam int unsigned IW = $clog2(HDR_QWORDS);
  localparam int unsigned WW = 7;
  localparam logic [15:0]   HDR_LEN  = 16'(HDR_QWORDS * 4 - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(HDR_QWORDS - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(META_WINDOW - 1);

  typedef enum logic [1:0] {CAP_FREE, CAP_WINDOW, CAP_HOLD} cap_state_e;
  typedef enum logic {EM_IDLE, EM_EMIT} em_state_e;

  logic          running_q, running_d;
  logic [31:0]   ev_ctr_q, ev_ctr_d;
  logic [15:0]   run_cfg_q;
  logic [15:0]   drop_q, drop_d;
  logic          event_q;
  logic          eligible, accept, drop, xfer, handshake;

  cap_state_e    cap_q;
  logic [WW-1:0] win_q;
  logic [31:0]   cap_ev_q, cap_sec_q, cap_time_q, cap_pps_q, cap_lpps_q;
  logic [MB-1:0] cap_meta_q, cap_meta_d;
  logic [NB-1:0] cap_vld_q, cap_vld_d;

  em_state_e     em_q;
  logic [IW-1:0] idx_q, idx_nxt;
  logic [31:0]   em_sec_q, em_time_q, em_pps_q, em_lpps_q;
  logic [MB-1:0] em_meta_q;
  logic [63:0]   tdata_q, next_word;
  logic          tvalid_q, tlast_q;

  always_comb begin
    eligible  = running_q && !runrst_i && !runstop_i;
    accept    = trig_i && eligible && (cap_q == CAP_FREE);
    drop      = trig_i && eligible && (cap_q != CAP_FREE);
    running_d = runrst_i ? 1'b1 : (runstop_i ? 1'b0 : running_q);
    xfer      = (cap_q == CAP_HOLD) && (em_q == EM_IDLE) && running_d;
    handshake = tvalid_q && m_thdr_tready;
    ev_ctr_d  = runrst_i ? '0 : (accept ? ev_ctr_q + 32'd1 : ev_ctr_q);
    if (runrst_i)
      drop_d = '0;
    else if (drop && (drop_q != '1))
      drop_d = drop_q + 16'd1;
    else
      drop_d = drop_q;
  end

  // Bytes load on acceptance and keep loading until first nonzero value
  always_comb begin
    cap_meta_d = cap_meta_q;
    cap_vld_d  = cap_vld_q;
    for (int unsigned b = 0; b < NB; b++) begin
      if (accept || ((cap_q == CAP_WINDOW) && !cap_vld_q[b])) begin
        cap_meta_d[b*8 +: 8] = metadata_i[b*8 +: 8];
        cap_vld_d[b]         = |metadata_i[b*8 +: 8];
      end
    end
  end

  always_comb begin
    idx_nxt   = idx_q + 1'b1;
    next_word = '0;
    if (idx_nxt == IW'(1))
      next_word = {em_time_q, em_sec_q};
    else if (idx_nxt == IW'(2))
      next_word = {em_lpps_q, em_pps_q};
    else if (idx_nxt == LAST_IDX)
      next_word = {16'(SURF_WORDS), run_cfg_q, 32'h0};
    else
      for (int unsigned t = 0; t < NT; t++)
        if (idx_nxt == IW'(t + 3)) next_word = em_meta_q[t*64 +: 64];
  end

  always_ff @(posedge sysclk or negedge sysresetn) begin
    if (!sysresetn) begin
      running_q <= 1'b0;
      ev_ctr_q  <= '0;
      run_cfg_q <= '0;
      drop_q    <= '0;
      event_q   <= 1'b0;
    end else begin
      running_q <= running_d;
      ev_ctr_q  <= ev_ctr_d;
      drop_q    <= drop_d;
      event_q   <= accept;
      if (runrst_i) run_cfg_q <= {4'(tio_mask_i), runcfg_i};
    end
  end

  always_ff @(posedge sysclk or negedge sysresetn) begin
    if (!sysresetn) begin
      cap_q      <= CAP_FREE;
      win_q      <= '0;
      cap_ev_q   <= '0;
      cap_sec_q  <= '0;
      cap_time_q <= '0;
      cap_pps_q  <= '0;
      cap_lpps_q <= '0;
      cap_meta_q <= '0;
      cap_vld_q  <= '0;
    end else begin
      cap_meta_q <= cap_meta_d;
      cap_vld_q  <= cap_vld_d;
      if (!running_d) begin
        cap_q <= CAP_FREE;
      end else begin
        case (cap_q)
          CAP_FREE: if (accept) begin
            cap_q      <= CAP_WINDOW;
            win_q      <= WW'(1);
            cap_ev_q   <= ev_ctr_q;
            cap_sec_q  <= cur_sec_i;
            cap_time_q <= cur_time_i;
            cap_pps_q  <= last_pps_i;
            cap_lpps_q <= llast_pps_i;
          end
          CAP_WINDOW: begin
            if (win_q == WIN_LAST) cap_q <= CAP_HOLD;
            else win_q <= win_q + 1'b1;
          end
          CAP_HOLD: if (xfer) cap_q <= CAP_FREE;
          default: cap_q <= CAP_FREE;
        endcase
      end
    end
  end

  // Emitter ignores run state so an in-flight packet always reaches tlast
  always_ff @(posedge sysclk or negedge sysresetn) begin
    if (!sysresetn) begin
      em_q      <= EM_IDLE;
      idx_q     <= '0;
      em_sec_q  <= '0;
      em_time_q <= '0;
      em_pps_q  <= '0;
      em_lpps_q <= '0;
      em_meta_q <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
    end else begin
      case (em_q)
        EM_IDLE: if (xfer) begin
          em_q      <= EM_EMIT;
          idx_q     <= '0;
          em_sec_q  <= cap_sec_q;
          em_time_q <= cap_time_q;
          em_pps_q  <= cap_pps_q;
          em_lpps_q <= cap_lpps_q;
          em_meta_q <= cap_meta_q;
          tdata_q   <= {cap_ev_q, 16'h4531, HDR_LEN};
          tvalid_q  <= 1'b1;
          tlast_q   <= 1'b0;
        end
        EM_EMIT: if (handshake) begin
          if (tlast_q) begin
            em_q     <= EM_IDLE;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
          end else begin
            idx_q   <= idx_nxt;
            tdata_q <= next_word;
            tlast_q <= (idx_nxt == LAST_IDX);
          end
        end
        default: em_q <= EM_IDLE;
      endcase
    end
  end

  assign event_o       = event_q;
  assign drop_count_o  = drop_q;
  assign m_thdr_tdata  = tdata_q;
  assign m_thdr_tvalid = tvalid_q;
  assign m_thdr_tlast  = tlast_q;

endmodule
